dmem_responder: RTL and testbench

//  Memory-side responder for the processor's data-memory request interface.

---
 rtl/dmem_responder_pkg.sv | 27 ++
 rtl/dmem_lane_align.sv | 60 ++++++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared size codes, FSM states and access-error rule for dmem_responder
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    localparam logic [0:1] DSIZE_BYTE = 2'b00;
    localparam logic [0:1] DSIZE_HALF = 2'b01;
    localparam logic [0:1] DSIZE_WORD = 2'b10;
    localparam logic [0:1] DSIZE_RSVD = 2'b11;

    // An access faults on reserved size, misalignment for its size, or a word index past the array
    function automatic logic access_error(
        input logic [0:1] size,
        input logic [0:1] offset,
        input logic       in_range
    );
        return !in_range
            || (size == DSIZE_RSVD)
            || ((size == DSIZE_HALF) && offset[1])
            || ((size == DSIZE_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - big-endian byte-lane steering for stores and load extraction/extension
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic [0:1]  i_offset,
    input  logic [0:1]  i_size,
    input  logic        i_sign,
    input  logic [0:31] i_wdata,
    input  logic [0:31] i_old_word,
    input  logic [0:31] i_word,
    output logic [0:3]  o_be,
    output logic [0:31] o_merged,
    output logic [0:31] o_rdata
);

    logic [0:31] w_wrep;
    logic [0:7]  w_rbyte;
    logic [0:15] w_rhalf;

    // Replicate right-justified store data into every lane and decode which lanes it lands on
    always_comb begin
        o_be   = 4'b0000;
        w_wrep = i_wdata;
        case (i_size)
            DSIZE_BYTE: begin
                w_wrep         = {4{i_wdata[24:31]}};
                o_be[i_offset] = 1'b1;
            end
            DSIZE_HALF: begin
                w_wrep = {2{i_wdata[16:31]}};
                o_be   = i_offset[0] ? 4'b0011 : 4'b1100;
            end
            DSIZE_WORD: o_be = 4'b1111;
            default:    o_be = 4'b0000;
        endcase
    end

    // Merge enabled lanes over the old word; disabled lanes keep their contents
    always_comb begin
        o_merged = i_old_word;
        for (int k = 0; k < 4; k++) begin
            if (o_be[k]) begin
                o_merged[8*k +: 8] = w_wrep[8*k +: 8];
            end
        end
    end

    // Pick the addressed lane, right-justify it and fill upper bits with its MSB or zero
    always_comb begin
        w_rbyte = i_word[8*i_offset +: 8];
        w_rhalf = i_word[16*i_offset[0] +: 16];
        o_rdata = i_word;
        case (i_size)
            DSIZE_BYTE: o_rdata = {{24{i_sign & w_rbyte[0]}}, w_rbyte};
            DSIZE_HALF: o_rdata = {{16{i_sign & w_rhalf[0]}}, w_rhalf};
            default:    o_rdata = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder with programmable access latency
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    LATENCY     = 2,
    parameter string MEM_FILE    = ""
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [0:31] req_addr,
    input  logic [0:31] req_wdata,
    input  logic        req_we,
    input  logic [0:1]  req_size,
    input  logic        req_sign,
    output logic        resp_valid,
    output logic [0:31] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    logic [0:31]      r_mem [0:DEPTH_WORDS-1];

    state_t           r_state;
    state_t           w_next_state;
    logic [3:0]       r_cnt;
    logic [0:31]      r_addr;
    logic [0:31]      r_wdata;
    logic             r_we;
    logic [0:1]       r_size;
    logic             r_sign;
    logic [0:31]      r_rdata;
    logic             r_err;

    logic             w_accept;
    logic             w_access;
    logic [31:0]      w_word_idx;
    logic             w_in_range;
    logic [IDX_W-1:0] w_mem_idx;
    logic [0:31]      w_old_word;
    logic             w_err;
    logic [0:3]       w_be;
    logic [0:31]      w_merged;
    logic [0:31]      w_load_word;

    assign w_accept   = (r_state == S_IDLE) && req_valid && !reset;
    assign w_access   = (r_state == S_WAIT) && (r_cnt == 4'd0) && !reset;

    // Out-of-range indexes are steered to word 0 so the array is never read past its end
    assign w_word_idx = {2'b00, r_addr[0:29]};
    assign w_in_range = (w_word_idx < 32'(DEPTH_WORDS));
    assign w_mem_idx  = w_in_range ? w_word_idx[IDX_W-1:0] : '0;
    assign w_old_word = r_mem[w_mem_idx];
    assign w_err      = access_error(r_size, r_addr[30:31], w_in_range);

    dmem_lane_align u_lane_align (
        .i_offset   (r_addr[30:31]),
        .i_size     (r_size),
        .i_sign     (r_sign),
        .i_wdata    (r_wdata),
        .i_old_word (w_old_word),
        .i_word     (w_old_word),
        .o_be       (w_be),
        .o_merged   (w_merged),
        .o_rdata    (w_load_word)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs; reset suppresses ready and any response pulse
    always_comb begin
        w_next_state = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        busy         = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy      = 1'b0;
                req_ready = !reset;
                if (req_valid) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid   = !reset;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Capture the request at acceptance and count down the access latency
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_size  <= DSIZE_BYTE;
            r_sign  <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= 4'(LATENCY - 1);
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_we    <= req_we;
            r_size  <= req_size;
            r_sign  <= req_sign;
        end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
            r_cnt   <= r_cnt - 4'd1;
        end
    end

    // Latch the response at the access edge; held until the next access
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_access) begin
            r_err   <= w_err;
            r_rdata <= (w_err || r_we) ? '0 : w_load_word;
        end
    end

    // Storage write at the access edge: merged word, only for a clean store
    always_ff @(posedge clk) begin
        if (w_access && r_we && !w_err && (|w_be)) begin
            r_mem[w_mem_idx] <= w_merged;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    logic        clk;
    logic        rst1, rst2;
    logic        v1, v2;
    logic [0:31] req_addr;
    logic [0:31] req_wdata;
    logic        req_we;
    logic [0:1]  req_size;
    logic        req_sign;

    logic        rdy1, rv1, er1, bz1;
    logic [0:31] rd1;
    logic        rdy2, rv2, er2, bz2;
    logic [0:31] rd2;

    int tests_run    = 0;
    int tests_failed = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .MEM_FILE("")) dut1 (
        .clk(clk), .reset(rst1), .req_valid(v1), .req_ready(rdy1),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign),
        .resp_valid(rv1), .resp_rdata(rd1), .resp_err(er1), .busy(bz1)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(3), .MEM_FILE("")) dut2 (
        .clk(clk), .reset(rst2), .req_valid(v2), .req_ready(rdy2),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we),
        .req_size(req_size), .req_sign(req_sign),
        .resp_valid(rv2), .resp_rdata(rd2), .resp_err(er2), .busy(bz2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on DUT 1 or 2, starting and ending 1 time unit after a rising edge
    task automatic xact(input int which, input logic we, input logic [0:1] size,
                        input logic sign, input logic [0:31] addr, input logic [0:31] wdata,
                        output logic [0:31] rdata, output logic err, output int lat);
        req_addr  = addr;
        req_wdata = wdata;
        req_we    = we;
        req_size  = size;
        req_sign  = sign;
        if (which == 1) v1 = 1'b1; else v2 = 1'b1;
        @(posedge clk); #1;
        v1 = 1'b0;
        v2 = 1'b0;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'h0BAD_F00D;
        req_we    = !we;
        req_sign  = !sign;
        lat   = -1;
        rdata = '0;
        err   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if ((which == 1) ? rv1 : rv2) begin
                lat   = i;
                rdata = (which == 1) ? rd1 : rd2;
                err   = (which == 1) ? er1 : er2;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst2 = 1'b1;
        v1 = 1'b1; v2 = 1'b1;
        req_addr = 32'h10; req_wdata = 32'h0; req_we = 1'b0; req_size = 2'b10; req_sign = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests_run++;
            if (rdy1 !== 1'b0) begin tests_failed++; $display("FAIL reset_ready cyc%0d: got %b want 0", c, rdy1); end
            tests_run++;
            if (rv1 !== 1'b0) begin tests_failed++; $display("FAIL reset_resp_valid cyc%0d: got %b want 0", c, rv1); end
            tests_run++;
            if (rd1 !== 32'h0) begin tests_failed++; $display("FAIL reset_rdata cyc%0d: got %h want 00000000", c, rd1); end
        end
        rst1 = 1'b0; rst2 = 1'b0;
        v1 = 1'b0; v2 = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (rdy1 !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready1: got %b want 1", rdy1); end
        tests_run++;
        if (rdy2 !== 1'b1) begin tests_failed++; $display("FAIL post_reset_ready2: got %b want 1", rdy2); end
        tests_run++;
        if (bz1 !== 1'b0) begin tests_failed++; $display("FAIL post_reset_busy: got %b want 0", bz1); end
    endtask

    task automatic test_word_rw();
        logic [0:31] d; logic e; int l;
        xact(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, d, e, l);
        tests_run++;
        if (l !== 2) begin tests_failed++; $display("FAIL store_latency: got %0d want 2", l); end
        tests_run++;
        if (e !== 1'b0 || d !== 32'h0) begin tests_failed++; $display("FAIL store_resp: got err=%b rdata=%h want err=0 rdata=00000000", e, d); end
        tests_run++;
        if (rv1 !== 1'b0) begin tests_failed++; $display("FAIL resp_pulse_width: got %b want 0", rv1); end
        xact(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e, l);
        tests_run++;
        if (l !== 2) begin tests_failed++; $display("FAIL load_latency: got %0d want 2", l); end
        tests_run++;
        if (d !== 32'hDEAD_BEEF || e !== 1'b0) begin tests_failed++; $display("FAIL word_load: got %h err=%b want deadbeef err=0", d, e); end
        tests_run++;
        if (rd1 !== 32'hDEAD_BEEF) begin tests_failed++; $display("FAIL rdata_hold: got %h want deadbeef", rd1); end
    endtask

    task automatic test_subword_load();
        logic [0:31] d; logic e; int l;
        xact(1, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'hFFFF_FFAD || e !== 1'b0) begin tests_failed++; $display("FAIL byte_load_sext: got %h err=%b want ffffffad", d, e); end
        xact(1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'h0000_00AD || e !== 1'b0) begin tests_failed++; $display("FAIL byte_load_zext: got %h err=%b want 000000ad", d, e); end
        xact(1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'hFFFF_BEEF || e !== 1'b0) begin tests_failed++; $display("FAIL half_load_sext: got %h err=%b want ffffbeef", d, e); end
        xact(1, 1'b0, 2'b00, 1'b1, 32'h10, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'hFFFF_FFDE) begin tests_failed++; $display("FAIL byte0_load_sext: got %h want ffffffde", d); end
    endtask

    task automatic test_byte_store();
        logic [0:31] d; logic e; int l;
        xact(1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_005A, d, e, l);
        xact(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'hDEAD_BE5A) begin tests_failed++; $display("FAIL byte_store_merge: got %h want deadbe5a", d); end
        xact(1, 1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_1234, d, e, l);
        xact(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'h1234_BE5A) begin tests_failed++; $display("FAIL half_store_merge: got %h want 1234be5a", d); end
        xact(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'h0000_005A) begin tests_failed++; $display("FAIL byte_load_positive: got %h want 0000005a", d); end
        xact(1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'h0000_1234) begin tests_failed++; $display("FAIL half0_load: got %h want 00001234", d); end
    endtask

    task automatic test_errors();
        logic [0:31] d; logic e; int l;
        xact(1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0, d, e, l);
        tests_run++;
        if (e !== 1'b1 || d !== 32'h0) begin tests_failed++; $display("FAIL err_half_misalign: got err=%b rdata=%h want err=1 rdata=00000000", e, d); end
        xact(1, 1'b1, 2'b10, 1'b0, 32'h12, 32'h1111_1111, d, e, l);
        tests_run++;
        if (e !== 1'b1 || d !== 32'h0) begin tests_failed++; $display("FAIL err_word_misalign: got err=%b rdata=%h want err=1 rdata=00000000", e, d); end
        xact(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'h1234_BE5A || e !== 1'b0) begin tests_failed++; $display("FAIL err_store_no_write: got %h err=%b want 1234be5a err=0", d, e); end
        xact(1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, d, e, l);
        tests_run++;
        if (e !== 1'b1 || d !== 32'h0) begin tests_failed++; $display("FAIL err_out_of_range: got err=%b rdata=%h want err=1 rdata=00000000", e, d); end
        xact(1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, d, e, l);
        tests_run++;
        if (e !== 1'b1 || d !== 32'h0) begin tests_failed++; $display("FAIL err_reserved_size: got err=%b rdata=%h want err=1 rdata=00000000", e, d); end
        tests_run++;
        if (l !== 2) begin tests_failed++; $display("FAIL err_latency: got %0d want 2", l); end
    endtask

    task automatic test_reset_midflight();
        logic [0:31] d; logic e; int l; logic seen;
        xact(2, 1'b1, 2'b10, 1'b0, 32'h20, 32'hA5A5_A5A5, d, e, l);
        tests_run++;
        if (l !== 3 || e !== 1'b0) begin tests_failed++; $display("FAIL lat3_store: got lat=%0d err=%b want lat=3 err=0", l, e); end
        req_addr = 32'h20; req_wdata = 32'h1234_5678; req_we = 1'b1; req_size = 2'b10; req_sign = 1'b0;
        v2 = 1'b1;
        @(posedge clk); #1;
        v2 = 1'b0;
        tests_run++;
        if (bz2 !== 1'b1) begin tests_failed++; $display("FAIL midflight_busy: got %b want 1", bz2); end
        rst2 = 1'b1;
        @(posedge clk); #1;
        rst2 = 1'b0;
        tests_run++;
        if (bz2 !== 1'b0) begin tests_failed++; $display("FAIL midflight_reset_idle: got busy=%b want 0", bz2); end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            seen = seen | rv2;
        end
        tests_run++;
        if (seen !== 1'b0) begin tests_failed++; $display("FAIL midflight_no_resp: got resp_valid=%b want 0", seen); end
        xact(2, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, d, e, l);
        tests_run++;
        if (d !== 32'hA5A5_A5A5 || l !== 3) begin tests_failed++; $display("FAIL midflight_store_lost: got %h lat=%0d want a5a5a5a5 lat=3", d, l); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_subword_load();
        test_byte_store();
        test_errors();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
